// File: rtl/sigfmd_iter.sv
// Significand multiply/divide unit: pipelined multiplier, radix-2 non-restoring divider.
// Optional macro SIGFMD_EARLY_TERM_EN ends a divide early once the partial remainder is exactly zero.
module sigfmd_iter #(
   parameter int SIG_W      = 53,
   parameter int SP_W       = 24,
   parameter int OUT_W      = SIG_W + 4,
   parameter int MUL_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SIG_W-1:0] fa,
   input  logic [SIG_W-1:0] fb,
   input  logic             fdiv,
   input  logic             db,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] fq,
   output logic             dbz
);
   localparam int QW = OUT_W - 1;
   localparam int RW = SIG_W + 3;
   localparam int CW = $clog2(OUT_W);
   localparam int PW = 2 * SIG_W;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MUL  = 3'd1;
   localparam logic [2:0] ST_DIV  = 3'd2;
   localparam logic [2:0] ST_FIN  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   logic [2:0]       state_reg;
   logic [SIG_W-1:0] fa_reg, fb_reg;
   logic             db_reg;
   logic [CW-1:0]    cnt_reg;
   logic [QW-1:0]    q_reg;
   logic [RW-1:0]    rem_reg;
   logic [OUT_W-1:0] fq_reg;
   logic             dbz_reg;

   logic [PW-1:0]    prod_comb, prod_last;
   logic [OUT_W-1:0] mul_fq;
   logic [RW-1:0]    b_ext, rem_next, rem_fix;
   logic [CW-1:0]    last_cnt, q_idx;
   logic             div_stop;

   assign in_ready  = (state_reg == ST_IDLE);
   assign out_valid = (state_reg == ST_DONE);
   assign fq        = fq_reg;
   assign dbz       = dbz_reg;

   assign prod_comb = {{SIG_W{1'b0}}, fa_reg} * {{SIG_W{1'b0}}, fb_reg};

   // Operand registers form the first multiply stage; extra stages retime the product.
   generate
      if (MUL_STAGES == 1) begin : g_mul_comb
         assign prod_last = prod_comb;
      end else begin : g_mul_pipe
         logic [PW-1:0] pipe [MUL_STAGES-1];
         always_ff @(posedge clk) begin
            pipe[0] <= prod_comb;
            for (int i = 1; i < MUL_STAGES - 1; i++) begin
               pipe[i] <= pipe[i-1];
            end
         end
         assign prod_last = pipe[MUL_STAGES-2];
      end
   endgenerate

   assign mul_fq = {prod_last[PW-1 -: QW], |prod_last[PW-OUT_W:0]};

   // Non-restoring step: sign of the shifted partial remainder picks add or subtract.
   assign b_ext    = {{(RW-SIG_W){1'b0}}, fb_reg};
   assign rem_next = rem_reg[RW-1] ? (rem_reg + b_ext) : (rem_reg - b_ext);
   assign rem_fix  = rem_reg[RW-1] ? (rem_reg + (b_ext << 1)) : rem_reg;
   assign last_cnt = db_reg ? CW'(QW - 1) : CW'(SP_W + 1);
   assign q_idx    = CW'(QW - 1) - cnt_reg;

`ifdef SIGFMD_EARLY_TERM_EN
   assign div_stop = (cnt_reg == last_cnt) || (rem_next == '0);
`else
   assign div_stop = (cnt_reg == last_cnt);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         fa_reg    <= '0;
         fb_reg    <= '0;
         db_reg    <= 1'b0;
         cnt_reg   <= '0;
         q_reg     <= '0;
         rem_reg   <= '0;
         fq_reg    <= '0;
         dbz_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  fa_reg    <= fa;
                  fb_reg    <= fb;
                  db_reg    <= db;
                  cnt_reg   <= '0;
                  q_reg     <= '0;
                  rem_reg   <= {{(RW-SIG_W){1'b0}}, fa};
                  state_reg <= fdiv ? ST_DIV : ST_MUL;
               end
            end
            ST_MUL: begin
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == CW'(MUL_STAGES - 1)) begin
                  fq_reg    <= mul_fq;
                  dbz_reg   <= 1'b0;
                  state_reg <= ST_DONE;
               end
            end
            ST_DIV: begin
               if (fb_reg == '0) begin
                  fq_reg    <= '1;
                  dbz_reg   <= 1'b1;
                  state_reg <= ST_DONE;
               end else begin
                  // Quotient MSB always lands at q_reg[QW-1]; unused low bits stay zero.
                  q_reg[q_idx] <= ~rem_next[RW-1];
                  rem_reg      <= rem_next << 1;
                  cnt_reg      <= cnt_reg + 1'b1;
                  if (div_stop) begin
                     state_reg <= ST_FIN;
                  end
               end
            end
            ST_FIN: begin
               fq_reg    <= {q_reg, |rem_fix};
               dbz_reg   <= 1'b0;
               state_reg <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end
endmodule
